// File: rtl/q_vec_otf_select.sv
// On-the-fly quotient vector assembly (MSB-first signed digits) with registered
// signed-digit product d*Q, captured under the master LOAD/RUN rules.
module q_vec_otf_select #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CNT_W    = 9,
    parameter int unsigned LOAD_CNT = 4,
    parameter int unsigned D_DELAY  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   state,
    input  logic [CNT_W-1:0]             cnt_master,
    input  logic                         first_cycle,
    input  logic                         start,
    input  logic                         dig_valid,
    input  logic                         q_dig_plus,
    input  logic                         q_dig_minus,
    input  logic                         d_plus,
    input  logic                         d_minus,
    output logic [WIDTH-1:0]             q_vec_plus,
    output logic [WIDTH-1:0]             q_vec_minus,
    output logic [WIDTH-1:0]             sel_plus,
    output logic [WIDTH-1:0]             sel_minus,
    output logic                         sel_valid,
    output logic [$clog2(WIDTH+1)-1:0]   digit_cnt,
    output logic                         full,
    output logic                         overflow
);

    localparam int unsigned CntW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StInit = 2'b01,
        StLoad = 2'b10,
        StRun  = 2'b11
    } master_state_e;

    logic [WIDTH-1:0] qp_q, qm_q, qp_d, qm_d;
    logic [WIDTH-1:0] selp_q, selm_q, prod_p, prod_m;
    logic [CntW-1:0]  cnt_q, cnt_d, idx;
    logic             ovf_q, ovf_d, selv_q;
    logic [1:0]       d_q, d_norm, d_eff;
    logic             qd_p, qd_m;
    logic             active, append, ovf_set, capture;
    master_state_e    mstate;

    assign mstate = master_state_e'(state);

    // Rail pair 11 is not a legal digit; treat it as zero.
    assign qd_p   = q_dig_plus & ~q_dig_minus;
    assign qd_m   = q_dig_minus & ~q_dig_plus;
    assign d_norm = {d_plus & ~d_minus, d_minus & ~d_plus};
    assign d_eff  = (D_DELAY != 0) ? d_q : d_norm;

    assign full    = (cnt_q == CntW'(WIDTH));
    assign active  = (mstate == StLoad) || (mstate == StRun);
    assign append  = dig_valid & ~start & active & ~full;
    assign ovf_set = dig_valid & ~start & active & full;
    assign idx     = CntW'(WIDTH - 1) - cnt_q;

    assign capture = ((mstate == StLoad) &&
                      (first_cycle || (cnt_master == CNT_W'(LOAD_CNT)))) ||
                     (mstate == StRun);

    always_comb begin
        qp_d  = qp_q;
        qm_d  = qm_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (start) begin
            qp_d  = '0;
            qm_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (append) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (idx == CntW'(i)) begin
                    qp_d[i] = qd_p;
                    qm_d[i] = qd_m;
                end
            end
            cnt_d = cnt_q + CntW'(1);
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    // Product uses the vector as registered, before this cycle's append.
    always_comb begin
        prod_p = '0;
        prod_m = '0;
        case (d_eff)
            2'b10: begin
                prod_p = qp_q;
                prod_m = qm_q;
            end
            2'b01: begin
                prod_p = qm_q;
                prod_m = qp_q;
            end
            default: begin
                prod_p = '0;
                prod_m = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qp_q   <= '0;
            qm_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            d_q    <= 2'b00;
            selp_q <= '0;
            selm_q <= '0;
            selv_q <= 1'b0;
        end else begin
            qp_q   <= qp_d;
            qm_q   <= qm_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            d_q    <= d_norm;
            selv_q <= capture;
            if (capture) begin
                selp_q <= prod_p;
                selm_q <= prod_m;
            end
        end
    end

    assign q_vec_plus  = qp_q;
    assign q_vec_minus = qm_q;
    assign sel_plus    = selp_q;
    assign sel_minus   = selm_q;
    assign sel_valid   = selv_q;
    assign digit_cnt   = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_q_vec_otf_select.sv
// Directed bench for q_vec_otf_select; a second instance covers the delayed-d path.
module tb_q_vec_otf_select;

    logic       clk, rst;
    logic [1:0] state;
    logic [8:0] cnt_master;
    logic       first_cycle, start, dig_valid;
    logic       q_dig_plus, q_dig_minus, d_plus, d_minus;

    logic [3:0] qvp, qvm, selp, selm, qvp2, qvm2, selp2, selm2;
    logic [2:0] dcnt, dcnt2;
    logic       selv, full, ovf, selv2, full2, ovf2;

    int n_tests = 0;
    int n_fail  = 0;

    q_vec_otf_select #(.WIDTH(4), .CNT_W(9), .LOAD_CNT(4), .D_DELAY(0)) dut (
        .clk(clk), .rst(rst), .state(state), .cnt_master(cnt_master),
        .first_cycle(first_cycle), .start(start), .dig_valid(dig_valid),
        .q_dig_plus(q_dig_plus), .q_dig_minus(q_dig_minus),
        .d_plus(d_plus), .d_minus(d_minus),
        .q_vec_plus(qvp), .q_vec_minus(qvm), .sel_plus(selp), .sel_minus(selm),
        .sel_valid(selv), .digit_cnt(dcnt), .full(full), .overflow(ovf)
    );

    q_vec_otf_select #(.WIDTH(4), .CNT_W(9), .LOAD_CNT(4), .D_DELAY(1)) dut_dly (
        .clk(clk), .rst(rst), .state(state), .cnt_master(cnt_master),
        .first_cycle(first_cycle), .start(start), .dig_valid(dig_valid),
        .q_dig_plus(q_dig_plus), .q_dig_minus(q_dig_minus),
        .d_plus(d_plus), .d_minus(d_minus),
        .q_vec_plus(qvp2), .q_vec_minus(qvm2), .sel_plus(selp2), .sel_minus(selm2),
        .sel_valid(selv2), .digit_cnt(dcnt2), .full(full2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dig(input logic v, input logic [1:0] q);
        dig_valid   = v;
        q_dig_plus  = q[1];
        q_dig_minus = q[0];
    endtask

    task automatic set_d(input logic [1:0] d);
        d_plus  = d[1];
        d_minus = d[0];
    endtask

    task automatic load_vector();
        // +1, -1, 0, +1 -> plus 1001, minus 0100
        start = 1'b1; set_dig(1'b0, 2'b00); tick();
        start = 1'b0;
        set_dig(1'b1, 2'b10); tick();
        set_dig(1'b1, 2'b01); tick();
        set_dig(1'b1, 2'b00); tick();
        set_dig(1'b1, 2'b10); tick();
        set_dig(1'b0, 2'b00);
    endtask

    initial begin
        rst = 1'b1; state = 2'b00; cnt_master = '0; first_cycle = 1'b0;
        start = 1'b0; set_dig(1'b0, 2'b00); set_d(2'b00);
        #12;
        check("rst_qvp", qvp, 0);
        check("rst_selp", selp, 0);
        check("rst_selv", selv, 0);
        check("rst_cnt", dcnt, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        // Digits are ignored in IDLE
        set_dig(1'b1, 2'b10); tick();
        check("idle_qvp", qvp, 0);
        check("idle_cnt", dcnt, 0);

        state = 2'b11;
        start = 1'b1; set_dig(1'b0, 2'b00); tick();
        start = 1'b0;
        set_dig(1'b1, 2'b10); tick();
        check("acc1_qvp", qvp, 4'b1000);
        check("acc1_cnt", dcnt, 1);
        check("acc1_full", full, 0);
        set_dig(1'b1, 2'b01); tick();
        set_dig(1'b1, 2'b00); tick();
        set_dig(1'b1, 2'b10); tick();
        set_dig(1'b0, 2'b00);
        check("acc_qvp", qvp, 4'b1001);
        check("acc_qvm", qvm, 4'b0100);
        check("acc_cnt", dcnt, 4);
        check("acc_full", full, 1);

        // Selection in RUN
        set_d(2'b01); tick();
        check("neg_selp", selp, 4'b0100);
        check("neg_selm", selm, 4'b1001);
        check("neg_selv", selv, 1);
        set_d(2'b00); tick();
        check("zero_selp", selp, 0);
        check("zero_selm", selm, 0);
        set_d(2'b10); tick();
        check("pos_selp", selp, 4'b1001);
        check("pos_selm", selm, 4'b0100);
        set_d(2'b11); tick();
        check("d11_selp", selp, 0);
        check("d11_selm", selm, 0);

        // LOAD gating
        state = 2'b10; set_d(2'b10); cnt_master = 9'd3; first_cycle = 1'b0; tick();
        check("ld3_selp", selp, 0);
        check("ld3_selv", selv, 0);
        cnt_master = 9'd4; tick();
        check("ld4_selp", selp, 4'b1001);
        check("ld4_selm", selm, 4'b0100);
        check("ld4_selv", selv, 1);
        cnt_master = 9'd5; tick();
        check("ld5_selv", selv, 0);
        check("ld5_selp", selp, 4'b1001);
        set_d(2'b01); cnt_master = 9'd6; tick();
        check("ld6_selp", selp, 4'b1001);
        cnt_master = 9'd7; first_cycle = 1'b1; tick();
        check("fc_selp", selp, 4'b0100);
        check("fc_selm", selm, 4'b1001);
        check("fc_selv", selv, 1);
        first_cycle = 1'b0; cnt_master = 9'd8;

        // Overflow and clear
        set_dig(1'b1, 2'b10); tick();
        check("ovf_set", ovf, 1);
        check("ovf_qvp", qvp, 4'b1001);
        check("ovf_qvm", qvm, 4'b0100);
        check("ovf_cnt", dcnt, 4);
        set_dig(1'b0, 2'b00); tick();
        check("ovf_sticky", ovf, 1);
        start = 1'b1; set_dig(1'b1, 2'b10); tick();
        start = 1'b0; set_dig(1'b0, 2'b00);
        check("clr_qvp", qvp, 0);
        check("clr_qvm", qvm, 0);
        check("clr_cnt", dcnt, 0);
        check("clr_ovf", ovf, 0);
        check("clr_full", full, 0);

        // Delayed d path
        state = 2'b11; set_d(2'b00);
        load_vector();
        check("dly_qvp", qvp2, 4'b1001);
        set_d(2'b10); tick();
        check("dlyA_selp", selp2, 0);
        check("nodlyA_selp", selp, 4'b1001);
        set_d(2'b01); tick();
        check("dlyB_selp", selp2, 4'b1001);
        check("dlyB_selm", selm2, 4'b0100);
        check("nodlyB_selp", selp, 4'b0100);
        set_d(2'b00); tick();
        check("dlyC_selp", selp2, 4'b0100);
        check("dlyC_selm", selm2, 4'b1001);
        check("nodlyC_selp", selp, 0);

        // Asynchronous reset mid-cycle
        set_d(2'b10); tick();
        check("pre_rst_selp", selp, 4'b1001);
        #2 rst = 1'b1;
        #1;
        check("arst_selp", selp, 0);
        check("arst_selv", selv, 0);
        check("arst_qvp", qvp, 0);
        check("arst_cnt", dcnt, 0);
        check("arst_selp2", selp2, 0);
        #3 rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
